instr_stream_encoder: RTL and testbench

//  Inverse of the control decoder: packs opcode/register/immediate fields into 16-bit instruction words.

---
 rtl/instr_stream_encoder_pkg.sv | 63 ++++++
 rtl/instr_stream_encoder_field_pack.sv | 52 +++++
 rtl/instr_stream_encoder.sv | 132 +++++++++++++
 tb/tb_instr_stream_encoder.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_stream_encoder_pkg.sv
// Shared definitions for the instruction stream encoder.
//  - Opcode values, identical to the control decoder's table.
//  - Instruction format classes used to pick the field packing.
//  - Loader FSM state constants.
//  - Helper that checks whether a signed immediate fits a field's legal range.
package instr_stream_encoder_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_RED    = 4'h2;
  localparam logic [3:0] OP_XOR    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  // Loader FSM states (plain constants so older tools can dump them as-is)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [2:0] {
    FMT_RRR,     // {op, rd, rs, rt}
    FMT_SHIFT,   // {op, rd, rs, imm[3:0]}, unsigned shift amount
    FMT_MEM,     // {op, rd, rs, imm[3:0]}, signed word offset
    FMT_BYTE,    // {op, rd, imm[7:0]}
    FMT_BRANCH,  // {op, cond, imm[8:0]}
    FMT_BREG,    // {op, cond, 0, rs, 0000}
    FMT_PCS,     // {op, rd, 00000000}
    FMT_HALT     // {op, 000000000000}
  } instr_fmt_t;

  function automatic instr_fmt_t op_format(input logic [3:0] op);
    instr_fmt_t fmt;
    case (op)
      OP_ADD, OP_SUB, OP_RED, OP_XOR, OP_PADDSB: fmt = FMT_RRR;
      OP_SLL, OP_SRA, OP_ROR:                    fmt = FMT_SHIFT;
      OP_LW, OP_SW:                              fmt = FMT_MEM;
      OP_LHB, OP_LLB:                            fmt = FMT_BYTE;
      OP_B:                                      fmt = FMT_BRANCH;
      OP_BR:                                     fmt = FMT_BREG;
      OP_PCS:                                    fmt = FMT_PCS;
      default:                                   fmt = FMT_HALT;
    endcase
    return fmt;
  endfunction

  // The immediate arrives as a 16-bit two's complement value; LLB/LHB accept
  // both signed and unsigned byte views, hence asymmetric bounds.
  function automatic logic imm_fits(input logic signed [15:0] value, input int lo, input int hi);
    return (int'(value) >= lo) && (int'(value) <= hi);
  endfunction

endpackage

// File: rtl/instr_stream_encoder_field_pack.sv
// Combinational field packer: turns one {opcode, rd, rs, rt, cond, imm} tuple
// into a 16-bit instruction word and reports whether the immediate fits the
// field it is packed into. Fields an opcode does not use are ignored.
// Ports:
//  opcode, rd, rs, rt  in  4   instruction fields
//  cond                in  3   branch condition (B/BR)
//  imm                 in  16  signed immediate before truncation
//  word                out 16  packed instruction
//  range_ok            out 1   immediate is legal for this opcode
module instr_stream_encoder_field_pack
  import instr_stream_encoder_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [3:0]  rd,
  input  logic [3:0]  rs,
  input  logic [3:0]  rt,
  input  logic [2:0]  cond,
  input  logic [15:0] imm,
  output logic [15:0] word,
  output logic        range_ok
);

  // Select packing by format class; HLT is the fall-through encoding.
  always_comb begin
    word     = {opcode, 12'h000};
    range_ok = 1'b1;
    case (op_format(opcode))
      FMT_RRR: word = {opcode, rd, rs, rt};
      FMT_SHIFT: begin
        word     = {opcode, rd, rs, imm[3:0]};
        range_ok = imm_fits($signed(imm), 0, 15);
      end
      FMT_MEM: begin
        // Decoder sign-extends bit 3, so only -8..7 survives the round trip
        word     = {opcode, rd, rs, imm[3:0]};
        range_ok = imm_fits($signed(imm), -8, 7);
      end
      FMT_BYTE: begin
        word     = {opcode, rd, imm[7:0]};
        range_ok = imm_fits($signed(imm), -128, 255);
      end
      FMT_BRANCH: begin
        word     = {opcode, cond, imm[8:0]};
        range_ok = imm_fits($signed(imm), -256, 255);
      end
      FMT_BREG: word = {opcode, cond, 1'b0, rs, 4'h0};
      FMT_PCS:  word = {opcode, rd, 8'h00};
      default:  word = {opcode, 12'h000};
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Instruction stream encoder: packs field tuples into 16-bit instruction words
// and streams them into instruction memory ahead of the core leaving reset.
// Stops on HLT (after its write is acknowledged) or on capacity overflow.
// Ports:
//  clk, rst                    clock, asynchronous active-high reset
//  start                       begin a new load (only from IDLE/DONE)
//  in_valid / in_ready         tuple handshake
//  opcode, rd, rs, rt, cond, imm  tuple fields
//  mem_we, mem_addr, mem_wdata write request, held until mem_ack
//  mem_ack                     memory accepted the write this cycle
//  done                        HLT written or overflow; level until start/rst
//  err, err_addr               sticky error flag and address of first bad tuple
//  word_count                  words acknowledged since start
module instr_stream_encoder
  import instr_stream_encoder_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [3:0]        rd,
  input  logic [3:0]        rs,
  input  logic [3:0]        rt,
  input  logic [2:0]        cond,
  input  logic [15:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [10:0]       word_count
);

  logic [1:0]        state;
  logic [15:0]       packed_word;
  logic              range_ok;
  logic              accept;
  logic              write_done;
  logic              overflow;
  logic [10:0]       eff_count;
  logic [ADDR_W-1:0] slot_addr;

  instr_stream_encoder_field_pack u_pack (
    .opcode   (opcode),
    .rd       (rd),
    .rs       (rs),
    .rt       (rt),
    .cond     (cond),
    .imm      (imm),
    .word     (packed_word),
    .range_ok (range_ok)
  );

  // A new tuple may be taken in the same cycle the previous write is acked.
  // In that case the acked word already counts toward the slot the new tuple
  // would occupy, so the slot index is word_count plus the outstanding write.
  assign in_ready   = (state == ST_LOAD) && (!mem_we || mem_ack);
  assign accept     = in_valid && in_ready;
  assign write_done = mem_we && mem_ack;
  assign eff_count  = word_count + {10'b0, mem_we};
  assign overflow   = (eff_count >= 11'(MAX_WORDS));
  assign slot_addr  = BASE_ADDR + (ADDR_W'(eff_count) << 1);
  assign mem_addr   = BASE_ADDR + (ADDR_W'(word_count) << 1);

  // Loader FSM with the output register, word counter and first-error capture.
  // Reset is asynchronous so an in-flight write request drops immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_addr   <= '0;
      word_count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_LOAD;
            word_count <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
            err_addr   <= '0;
          end
        end
        ST_LOAD: begin
          if (write_done) begin
            mem_we     <= 1'b0;
            word_count <= word_count + 11'd1;
          end
          if (accept) begin
            if (overflow) begin
              err   <= 1'b1;
              if (!err) err_addr <= slot_addr;
              done  <= 1'b1;
              state <= ST_DONE;
            end else if (!range_ok) begin
              err <= 1'b1;
              if (!err) err_addr <= slot_addr;
            end else begin
              mem_we    <= 1'b1;
              mem_wdata <= packed_word;
              if (opcode == OP_HLT) state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (write_done) begin
            mem_we     <= 1'b0;
            word_count <= word_count + 11'd1;
            done       <= 1'b1;
            state      <= ST_DONE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Testbench for instr_stream_encoder: table of single-tuple encodings with
// hand-computed words, directed multi-cycle sequences, and a randomized stream
// compared every cycle against a behavioural model of the loader.
module tb_instr_stream_encoder;
  import instr_stream_encoder_pkg::*;

  localparam int          ADDR_W    = 16;
  localparam logic [15:0] BASE_ADDR = 16'h0000;
  localparam int          MAX_WORDS = 1024;
  localparam int          P_IDLE = 0, P_LOAD = 1, P_DRAIN = 2, P_DONE = 3;
  localparam int          NVEC = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        opcode = '0, rd = '0, rs = '0, rt = '0;
  logic [2:0]        cond = '0;
  logic [15:0]       imm = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_ack = 1'b0;
  logic              done, err;
  logic [ADDR_W-1:0] err_addr;
  logic [10:0]       word_count;

  always #5 clk = ~clk;

  instr_stream_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .cond(cond), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .done(done), .err(err), .err_addr(err_addr), .word_count(word_count)
  );

  typedef struct {
    logic [3:0]  op, f_rd, f_rs, f_rt;
    logic [2:0]  f_cnd;
    int          f_imm;
    logic [15:0] exp_word;
    bit          exp_ok;
  } vec_t;

  vec_t tbl [NVEC];

  int n_vectors = 0;
  int n_miscompares = 0;

  // Behavioural model of the loader
  int          m_phase;
  bit          m_pending;
  logic [15:0] m_word;
  int          m_addr;
  int          m_count;
  bit          m_err;
  int          m_err_addr;
  bit          m_done;
  bit          m_acc;
  logic        last_ready;

  logic [15:0] wr_addr [$];
  logic [15:0] wr_data [$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Field packing computed arithmetically from the instruction formats
  function automatic void ref_encode(input int op, input int f_rd, input int f_rs, input int f_rt,
                                     input int f_cnd, input int f_imm, output int word, output bit ok);
    ok = 1'b1;
    case (op)
      0, 1, 2, 3, 7: word = op * 4096 + f_rd * 256 + f_rs * 16 + f_rt;
      4, 5, 6: begin
        ok   = (f_imm >= 0) && (f_imm <= 15);
        word = op * 4096 + f_rd * 256 + f_rs * 16 + (f_imm & 15);
      end
      8, 9: begin
        ok   = (f_imm >= -8) && (f_imm <= 7);
        word = op * 4096 + f_rd * 256 + f_rs * 16 + (f_imm & 15);
      end
      10, 11: begin
        ok   = (f_imm >= -128) && (f_imm <= 255);
        word = op * 4096 + f_rd * 256 + (f_imm & 255);
      end
      12: begin
        ok   = (f_imm >= -256) && (f_imm <= 255);
        word = op * 4096 + f_cnd * 512 + (f_imm & 511);
      end
      13:      word = op * 4096 + f_cnd * 512 + f_rs * 16;
      14:      word = op * 4096 + f_rd * 256;
      default: word = op * 4096;
    endcase
  endfunction

  function automatic void modelReset();
    m_phase = P_IDLE; m_pending = 0; m_word = '0; m_addr = BASE_ADDR;
    m_count = 0; m_err = 0; m_err_addr = 0; m_done = 0; m_acc = 0;
  endfunction

  function automatic void modelError(input int addr);
    if (!m_err) m_err_addr = addr;
    m_err = 1;
  endfunction

  // One clock cycle: drive at the falling edge, compare all outputs against the
  // model, then advance the model to what the next rising edge should produce.
  task automatic applyStimulus(input bit v, input bit s, input bit ack_req,
                               input logic [3:0] op, input logic [3:0] f_rd, input logic [3:0] f_rs,
                               input logic [3:0] f_rt, input logic [2:0] f_cnd, input int f_imm);
    int w;
    bit ok, ack, ready, ackw;
    int slot;
    @(negedge clk);
    ack = ack_req && m_pending;
    mem_ack = ack; in_valid = v; start = s;
    opcode = op; rd = f_rd; rs = f_rs; rt = f_rt; cond = f_cnd; imm = 16'(f_imm);
    #1;
    ready = (m_phase == P_LOAD) && (!m_pending || ack);
    checkOutput("mem_we", mem_we, m_pending);
    if (m_pending) begin
      checkOutput("mem_wdata", mem_wdata, m_word);
      checkOutput("mem_addr_slot", mem_addr, m_addr);
    end
    checkOutput("mem_addr", mem_addr, BASE_ADDR + 2 * m_count);
    checkOutput("word_count", word_count, m_count);
    checkOutput("err", err, m_err);
    checkOutput("err_addr", err_addr, m_err_addr);
    checkOutput("done", done, m_done);
    checkOutput("in_ready", in_ready, ready);
    last_ready = in_ready;
    if (mem_we && mem_ack) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    m_acc = v && ready;
    ackw  = m_pending && ack;
    case (m_phase)
      P_IDLE, P_DONE: begin
        if (s) begin
          m_phase = P_LOAD; m_count = 0; m_err = 0; m_err_addr = 0; m_done = 0;
        end
      end
      P_LOAD: begin
        if (ackw) begin m_pending = 0; m_count++; end
        if (m_acc) begin
          ref_encode(int'(op), int'(f_rd), int'(f_rs), int'(f_rt), int'(f_cnd), f_imm, w, ok);
          slot = BASE_ADDR + 2 * m_count;
          if (m_count >= MAX_WORDS) begin
            modelError(slot); m_done = 1; m_phase = P_DONE;
          end else if (!ok) begin
            modelError(slot);
          end else begin
            m_pending = 1; m_word = w[15:0]; m_addr = slot;
            if (op == OP_HLT) m_phase = P_DRAIN;
          end
        end
      end
      default: begin
        if (ackw) begin m_pending = 0; m_count++; m_done = 1; m_phase = P_DONE; end
      end
    endcase
  endtask

  task automatic idle(input int n, input int ack_pct);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 0, $urandom_range(0, 99) < ack_pct, '0, '0, '0, '0, '0, 0);
  endtask

  task automatic pulseStart();
    applyStimulus(0, 1, 0, '0, '0, '0, '0, '0, 0);
  endtask

  task automatic sendTuple(input logic [3:0] op, input logic [3:0] f_rd, input logic [3:0] f_rs,
                           input logic [3:0] f_rt, input logic [2:0] f_cnd, input int f_imm,
                           input int ack_pct);
    int tries = 0;
    m_acc = 0;
    while (!m_acc && tries < 40) begin
      applyStimulus(1, 0, $urandom_range(0, 99) < ack_pct, op, f_rd, f_rs, f_rt, f_cnd, f_imm);
      tries++;
    end
    if (!m_acc) begin
      n_vectors++; n_miscompares++;
      $display("[TB] FAIL accept_timeout: tuple op %0h not accepted within 40 cycles", op);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1; in_valid = 0; start = 0; mem_ack = 0;
    #1;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, BASE_ADDR);
    checkOutput("rst_mem_wdata", mem_wdata, 16'h0000);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_err_addr", err_addr, 16'h0000);
    checkOutput("rst_word_count", word_count, 0);
    @(negedge clk);
    rst = 0;
    modelReset();
    wr_addr.delete(); wr_data.delete();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [3:0] r_op;
    bit         r_v, r_s, r_ack;
    int         r_imm, r_sel;

    tbl[0]  = '{OP_ADD,    4'h1, 4'h2, 4'h3, 3'h5, 1234,   16'h0123, 1'b1};
    tbl[1]  = '{OP_SUB,    4'hF, 4'hE, 4'hD, 3'h0, 0,      16'h1FED, 1'b1};
    tbl[2]  = '{OP_PADDSB, 4'h0, 4'h9, 4'hA, 3'h0, 0,      16'h709A, 1'b1};
    tbl[3]  = '{OP_SLL,    4'h1, 4'h1, 4'h7, 3'h0, 0,      16'h4110, 1'b1};
    tbl[4]  = '{OP_SRA,    4'h2, 4'h3, 4'h0, 3'h0, 15,     16'h523F, 1'b1};
    tbl[5]  = '{OP_ROR,    4'h2, 4'h3, 4'h0, 3'h0, -1,     16'h0000, 1'b0};
    tbl[6]  = '{OP_SW,     4'h1, 4'h2, 4'h0, 3'h0, -8,     16'h9128, 1'b1};
    tbl[7]  = '{OP_LW,     4'h1, 4'h2, 4'h0, 3'h0, 8,      16'h0000, 1'b0};
    tbl[8]  = '{OP_LHB,    4'h3, 4'h0, 4'h0, 3'h0, -128,   16'hA380, 1'b1};
    tbl[9]  = '{OP_LLB,    4'h0, 4'h0, 4'h0, 3'h0, 255,    16'hB0FF, 1'b1};
    tbl[10] = '{OP_LLB,    4'h3, 4'h0, 4'h0, 3'h0, 256,    16'h0000, 1'b0};
    tbl[11] = '{OP_B,      4'h0, 4'h0, 4'h0, 3'h7, -256,   16'hCF00, 1'b1};
    tbl[12] = '{OP_B,      4'h0, 4'h0, 4'h0, 3'h0, 256,    16'h0000, 1'b0};
    tbl[13] = '{OP_BR,     4'hF, 4'h7, 4'hF, 3'h5, 'h1234, 16'hDA70, 1'b1};
    tbl[14] = '{OP_PCS,    4'h4, 4'h9, 4'h9, 3'h0, 0,      16'hE400, 1'b1};
    tbl[15] = '{OP_HLT,    4'h5, 4'h6, 4'h7, 3'h7, 99,     16'hF000, 1'b1};

    modelReset();

    // Table: each tuple alone in a fresh load
    for (int i = 0; i < NVEC; i++) begin
      doReset();
      pulseStart();
      sendTuple(tbl[i].op, tbl[i].f_rd, tbl[i].f_rs, tbl[i].f_rt, tbl[i].f_cnd, tbl[i].f_imm, 100);
      idle(3, 100);
      if (tbl[i].exp_ok) begin
        checkOutput($sformatf("tbl%0d_nwrites", i), wr_data.size(), 1);
        if (wr_data.size() > 0) checkOutput($sformatf("tbl%0d_word", i), wr_data[0], tbl[i].exp_word);
      end else begin
        checkOutput($sformatf("tbl%0d_nwrites", i), wr_data.size(), 0);
        checkOutput($sformatf("tbl%0d_err", i), err, 1);
      end
    end

    // ADD then LW/LLB back-to-back with ack every cycle
    doReset(); pulseStart();
    sendTuple(OP_ADD, 4'h1, 4'h2, 4'h3, 3'h0, 0, 100);
    idle(2, 100);
    checkOutput("add_word", wr_data[0], 16'h0123);
    checkOutput("add_addr", wr_addr[0], 16'h0000);
    checkOutput("add_count", word_count, 1);

    doReset(); pulseStart();
    sendTuple(OP_LW, 4'h4, 4'h5, 4'h0, 3'h0, -2, 100);
    sendTuple(OP_LLB, 4'h6, 4'h0, 4'h0, 3'h0, 'hAB, 100);
    idle(2, 100);
    checkOutput("lw_word", wr_data[0], 16'h845E);
    checkOutput("lw_addr", wr_addr[0], 16'h0000);
    checkOutput("llb_word", wr_data[1], 16'hB6AB);
    checkOutput("llb_addr", wr_addr[1], 16'h0002);

    // Range error consumes the tuple without advancing the address
    doReset(); pulseStart();
    sendTuple(OP_SLL, 4'h1, 4'h1, 4'h0, 3'h0, 16, 100);
    idle(2, 100);
    checkOutput("sll_err", err, 1);
    checkOutput("sll_err_addr", err_addr, 16'h0000);
    checkOutput("sll_nwrites", wr_data.size(), 0);
    sendTuple(OP_ADD, 4'h1, 4'h2, 4'h3, 3'h0, 0, 100);
    idle(2, 100);
    checkOutput("after_err_addr", wr_addr[0], 16'h0000);
    checkOutput("after_err_count", word_count, 1);

    // Withheld ack stalls the next tuple; ack and accept then coincide
    doReset(); pulseStart();
    sendTuple(OP_XOR, 4'h7, 4'h8, 4'h9, 3'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, OP_SUB, 4'h1, 4'h1, 4'h1, 3'h0, 0);
      checkOutput("stall_ready", last_ready, 0);
    end
    applyStimulus(1, 0, 1, OP_SUB, 4'h1, 4'h1, 4'h1, 3'h0, 0);
    checkOutput("b2b_ready", last_ready, 1);
    idle(2, 100);
    checkOutput("b2b_word1", wr_data[1], 16'h1111);
    checkOutput("b2b_addr1", wr_addr[1], 16'h0002);

    // Branch then HLT; afterwards tuples are ignored
    doReset(); pulseStart();
    sendTuple(OP_B, 4'h0, 4'h0, 4'h0, 3'b010, -1, 100);
    sendTuple(OP_HLT, 4'h0, 4'h0, 4'h0, 3'h0, 0, 100);
    idle(2, 100);
    checkOutput("b_word", wr_data[0], 16'hC5FF);
    checkOutput("hlt_word", wr_data[1], 16'hF000);
    checkOutput("hlt_done", done, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, OP_ADD, 4'h1, 4'h1, 4'h1, 3'h0, 0);
    checkOutput("post_done_nwrites", wr_data.size(), 2);

    // Capacity: MAX_WORDS writes fit, the next tuple overflows
    doReset(); pulseStart();
    for (int i = 0; i < MAX_WORDS; i++)
      sendTuple(OP_ADD, 4'($urandom), 4'($urandom), 4'($urandom), 3'h0, 0, 70);
    sendTuple(OP_ADD, 4'h1, 4'h1, 4'h1, 3'h0, 0, 70);
    idle(2, 100);
    checkOutput("ovf_err", err, 1);
    checkOutput("ovf_done", done, 1);
    checkOutput("ovf_err_addr", err_addr, BASE_ADDR + 16'h0800);
    checkOutput("ovf_count", word_count, 11'd1024);
    checkOutput("ovf_nwrites", wr_data.size(), MAX_WORDS);

    // Reset during an outstanding write drops it at once
    doReset(); pulseStart();
    sendTuple(OP_ADD, 4'h1, 4'h1, 4'h1, 3'h0, 0, 0);
    @(negedge clk); #2;
    checkOutput("pre_rst_mem_we", mem_we, 1);
    rst = 1; #1;
    checkOutput("async_rst_mem_we", mem_we, 0);
    checkOutput("async_rst_in_ready", in_ready, 0);
    @(negedge clk); rst = 0;
    modelReset(); wr_addr.delete(); wr_data.delete();

    // Randomized stream against the model
    doReset();
    for (int i = 0; i < 1500; i++) begin
      r_s = (((m_phase == P_IDLE) || (m_phase == P_DONE)) && ($urandom_range(0, 99) < 30))
            || ($urandom_range(0, 99) < 3);
      r_v   = $urandom_range(0, 99) < 70;
      r_ack = $urandom_range(0, 99) < 60;
      r_op  = ($urandom_range(0, 99) < 3) ? OP_HLT : 4'($urandom_range(0, 14));
      r_sel = $urandom_range(0, 2);
      if (r_sel == 0)      r_imm = int'($urandom_range(0, 40)) - 20;
      else if (r_sel == 1) r_imm = int'($urandom_range(0, 600)) - 300;
      else                 r_imm = int'($signed(16'($urandom)));
      applyStimulus(r_v, r_s, r_ack, r_op, 4'($urandom), 4'($urandom), 4'($urandom), 3'($urandom), r_imm);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
